core_alu_mdu: RTL
=================

CORE_ALU_MDU -- requirements
Module: core_alu_mdu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default DATA_WIDTH from core_pkg (32), operand/result width; any even value >= 8.
REQ-002 SHALL have parameter ALU_CODE_W, default ALU_WIDTH_CODE from alu_control_pkg, opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port alu_control  input  ALU_CODE_W  operation code.
REQ-006 SHALL have ports alu_in_a, alu_in_b  input  DATA_WIDTH  operands.
REQ-007 SHALL have port alu_in_valid  input  1  request valid.
REQ-008 SHALL have port alu_in_ready  output  1  request accepted when valid&ready.
REQ-009 SHALL have port alu_out  output  DATA_WIDTH  registered result.
REQ-010 SHALL have port alu_out_valid  output  1  result valid.
REQ-011 SHALL have port alu_out_ready  input  1  consumer takes result when valid&ready.
REQ-012 SHALL have port alu_busy  output  1  high while in CALC.

Function
REQ-013 SHALL support single-cycle ops: add, sub, and, or, xor, slt, sltu, sll, srl, sra (shift amount = alu_in_b[$clog2(DATA_WIDTH)-1:0]).
REQ-014 SHALL support iterative ops: mul, mulh, mulhsu, mulhu, div, divu, rem, remu with RISC-V M semantics.
REQ-015 SHALL implement FSM IDLE -> (accept iterative op) CALC -> DONE; IDLE -> (accept single-cycle op) DONE; DONE -> (out handshake, no new accept) IDLE.
REQ-016 alu_in_ready SHALL be 1 in IDLE, and in DONE only when alu_out_ready=1; 0 in CALC.
REQ-017 Accept in DONE with simultaneous output handshake SHALL retire the old result and start the new op in the same cycle (back-to-back throughput 1/cycle for single-cycle ops).
REQ-018 Single-cycle op: alu_out_valid SHALL rise on the edge following acceptance (latency 1).
REQ-019 Iterative op: CALC SHALL last exactly DATA_WIDTH cycles, one radix-2 step per cycle; alu_out_valid rises DATA_WIDTH+1 edges after acceptance.
REQ-020 Operands and opcode SHALL be latched on acceptance; input changes afterwards have no effect.
REQ-021 alu_out and alu_out_valid SHALL hold stable while alu_out_valid=1 and alu_out_ready=0.
REQ-022 slt SHALL be true signed compare (correct on overflow), result zero-extended 0/1.
REQ-023 mul SHALL return low DATA_WIDTH bits; mulh/mulhsu/mulhu return high DATA_WIDTH bits of the 2*DATA_WIDTH signed/signed, signed/unsigned, unsigned/unsigned product.
REQ-024 Divide by zero: div/divu quotient SHALL be all-ones; rem/remu SHALL return dividend; latency unchanged.
REQ-025 Signed overflow (most-negative / -1): div SHALL return dividend, rem SHALL return 0.
REQ-026 Unknown opcode SHALL be accepted as single-cycle and return alu_none (0).
REQ-027 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; no flags.

Reset
REQ-028 While rst=1: state IDLE, alu_out=0, alu_out_valid=0, alu_busy=0, alu_in_ready=0; alu_in_ready returns to 1 the first cycle after release.
REQ-029 Reset asserted mid-CALC or in DONE SHALL discard the operation; no result is ever delivered for it.

Structure
REQ-030 New opcodes (alu_sll..alu_remu) and ALU_WIDTH_CODE widening SHALL be added to alu_control_pkg; FSM state enum SHALL live in core_pkg.
REQ-031 Iterative engine SHALL be sub-module core_mdu_iter (shift-add multiplier / restoring divider, sign fix-up at start and end); single-cycle ops stay in core_alu_mdu.

Verification (DATA_WIDTH=32)
REQ-032 add 0x7FFFFFFF+1, out_ready=1 -> alu_out=0x80000000, valid 1 cycle after accept; 4 back-to-back ops -> 4 results on consecutive cycles.
REQ-033 mulh 0x80000000*0x80000000 -> 0x40000000; mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; valid exactly 33 edges after accept, busy high 32 cycles.
REQ-034 div 7/0 -> 0xFFFFFFFF; remu 7/0 -> 7; div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0.
REQ-035 div -7/2 -> 0xFFFFFFFD, rem -> 0xFFFFFFFF; sra 0x80000000 by 0x21 -> 0xC0000000; slt 0x80000000<1 -> 1.
REQ-036 Hold alu_out_ready=0 10 cycles after result -> alu_out stable, alu_in_ready=0; change operands during CALC -> result unaffected.
REQ-037 Assert rst at CALC cycle 10 -> no out_valid afterwards; next op after release returns correct result.

Source files
------------

// File: rtl/alu_control_pkg.sv
// alu_control_pkg -- operation codes understood by core_alu_mdu.
//   ALU_WIDTH_CODE : width of the opcode field
//   alu_op_e       : opcode values; alu_none (0) is also the result
//                    returned for any unrecognised opcode
package alu_control_pkg;

  localparam int ALU_WIDTH_CODE = 5;

  typedef enum logic [ALU_WIDTH_CODE-1:0] {
    alu_none   = 5'd0,
    alu_add    = 5'd1,
    alu_sub    = 5'd2,
    alu_and    = 5'd3,
    alu_or     = 5'd4,
    alu_xor    = 5'd5,
    alu_slt    = 5'd6,
    alu_sltu   = 5'd7,
    alu_sll    = 5'd8,
    alu_srl    = 5'd9,
    alu_sra    = 5'd10,
    alu_mul    = 5'd11,
    alu_mulh   = 5'd12,
    alu_mulhsu = 5'd13,
    alu_mulhu  = 5'd14,
    alu_div    = 5'd15,
    alu_divu   = 5'd16,
    alu_rem    = 5'd17,
    alu_remu   = 5'd18
  } alu_op_e;

endpackage

// File: rtl/core_pkg.sv
// core_pkg -- shared core-level constants and types.
//   DATA_WIDTH  : default datapath width
//   alu_state_e : control FSM states of core_alu_mdu
//   mdu_op_e    : operation selector for the iterative engine core_mdu_iter
package core_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_calc = 2'd1,
    st_done = 2'd2
  } alu_state_e;

  typedef enum logic [2:0] {
    mdu_mul    = 3'd0,
    mdu_mulh   = 3'd1,
    mdu_mulhsu = 3'd2,
    mdu_mulhu  = 3'd3,
    mdu_div    = 3'd4,
    mdu_divu   = 3'd5,
    mdu_rem    = 3'd6,
    mdu_remu   = 3'd7
  } mdu_op_e;

endpackage

// File: rtl/core_mdu_iter.sv
// core_mdu_iter -- radix-2 iterative multiply/divide engine.
// Operands are converted to magnitudes when start is pulsed; each step_en
// cycle performs one shift-add (multiply) or restoring-subtract (divide)
// step. On the DATA_WIDTH-th step, last is high and result carries the
// sign-corrected answer computed from that step's outcome, so the caller
// can register it on the same edge.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : load op/op_a/op_b and clear the step counter
//   op             : mdu_op_e selector (sampled on start)
//   op_a, op_b     : operands (sampled on start)
//   step_en        : perform one iteration this cycle
//   last           : this step is the final one
//   result         : final result, meaningful while last=1
module core_mdu_iter
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  mdu_op_e               op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  step_en,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  mdu_op_e       op_reg;
  logic [W-1:0]  hi_reg;     // product high half / partial remainder
  logic [W-1:0]  lo_reg;     // multiplier bits   / dividend -> quotient
  logic [W-1:0]  mcand_reg;  // multiplicand      / divisor magnitude
  logic          neg_q_reg;  // negate product or quotient at the end
  logic          neg_r_reg;  // negate remainder (follows dividend sign)
  logic          div_zero_reg;
  logic [CW-1:0] count_reg;

  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] a_abs, b_abs;

  always_comb begin
    a_signed = op inside {mdu_mulh, mdu_mulhsu, mdu_div, mdu_rem};
    b_signed = op inside {mdu_mulh, mdu_div, mdu_rem};
    a_neg    = a_signed & op_a[W-1];
    b_neg    = b_signed & op_b[W-1];
    // The most-negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    a_abs    = a_neg ? -op_a : op_a;
    b_abs    = b_neg ? -op_b : op_b;
  end

  logic         is_div;
  logic [W:0]   mul_sum, div_shift, div_diff;
  logic         div_ge;
  logic [W-1:0] hi_next, lo_next;

  always_comb begin
    is_div    = op_reg inside {mdu_div, mdu_divu, mdu_rem, mdu_remu};
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole 2W product right.
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
    // Restoring divide: bring in the next dividend bit and keep the
    // difference only if it did not go negative.
    div_shift = {hi_reg, lo_reg[W-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    div_ge    = ~div_diff[W];
    if (is_div) begin
      hi_next = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
      lo_next = {lo_reg[W-2:0], div_ge};
    end else begin
      hi_next = mul_sum[W:1];
      lo_next = {mul_sum[0], lo_reg[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg       <= mdu_mul;
      hi_reg       <= '0;
      lo_reg       <= '0;
      mcand_reg    <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      count_reg    <= '0;
    end else if (start) begin
      op_reg       <= op;
      hi_reg       <= '0;
      lo_reg       <= a_abs;
      mcand_reg    <= b_abs;
      neg_q_reg    <= a_neg ^ b_neg;
      neg_r_reg    <= a_neg;
      div_zero_reg <= (op_b == '0);
      count_reg    <= '0;
    end else if (step_en) begin
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      count_reg    <= count_reg + 1'b1;
    end
  end

  assign last = step_en && (count_reg == CW'(W - 1));

  logic [2*W-1:0] prod, prod_fix;

  always_comb begin
    prod     = {hi_next, lo_next};
    prod_fix = neg_q_reg ? -prod : prod;
    case (op_reg)
      mdu_mul:                         result = lo_next;
      mdu_mulh, mdu_mulhsu, mdu_mulhu: result = prod_fix[2*W-1:W];
      // A zero divisor naturally yields an all-ones magnitude quotient,
      // but the signed fix-up would flip it, so force it explicitly. The
      // remainder path already returns the dividend in that case.
      mdu_div, mdu_divu:               result = div_zero_reg ? '1 :
                                                (neg_q_reg ? -lo_next : lo_next);
      default:                         result = neg_r_reg ? -hi_next : hi_next;
    endcase
  end

endmodule

// File: rtl/core_alu_mdu.sv
// core_alu_mdu -- ALU with iterative multiply/divide and valid/ready
// handshakes on both the request and result sides.
// Single-cycle ops are evaluated combinationally from the request and
// registered on acceptance; M-extension ops run in core_mdu_iter for
// DATA_WIDTH cycles. A result held in DONE may be retired in the same cycle
// a new request is accepted.
//   clk, rst                    : clock, asynchronous active-high reset
//   alu_control                 : opcode (alu_op_e values)
//   alu_in_a, alu_in_b          : operands
//   alu_in_valid / alu_in_ready : request handshake
//   alu_out                     : registered result
//   alu_out_valid/alu_out_ready : result handshake
//   alu_busy                    : iterative operation in progress
module core_alu_mdu
  import core_pkg::*;
  import alu_control_pkg::*;
#(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
  parameter int ALU_CODE_W = alu_control_pkg::ALU_WIDTH_CODE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_CODE_W-1:0] alu_control,
  input  logic [DATA_WIDTH-1:0] alu_in_a,
  input  logic [DATA_WIDTH-1:0] alu_in_b,
  input  logic                  alu_in_valid,
  output logic                  alu_in_ready,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  alu_out_valid,
  input  logic                  alu_out_ready,
  output logic                  alu_busy
);

  localparam int SHW = $clog2(DATA_WIDTH);

  alu_state_e            state_reg, state_next;
  logic [DATA_WIDTH-1:0] alu_out_reg;
  logic                  accept;
  logic                  is_iter;
  mdu_op_e               mdu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  iter_last;
  logic [DATA_WIDTH-1:0] iter_result;
  logic [SHW-1:0]        shamt;

  logic [DATA_WIDTH-1:0] and_bits, or_bits, xor_bits;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bitwise
    assign and_bits[gi] = alu_in_a[gi] & alu_in_b[gi];
    assign or_bits[gi]  = alu_in_a[gi] | alu_in_b[gi];
    assign xor_bits[gi] = alu_in_a[gi] ^ alu_in_b[gi];
  end

  // Opcode decode and single-cycle datapath.
  always_comb begin
    shamt      = alu_in_b[SHW-1:0];
    alu_result = '0;
    is_iter    = 1'b0;
    mdu_op     = mdu_mul;
    case (alu_control)
      ALU_CODE_W'(alu_add):    alu_result = alu_in_a + alu_in_b;
      ALU_CODE_W'(alu_sub):    alu_result = alu_in_a - alu_in_b;
      ALU_CODE_W'(alu_and):    alu_result = and_bits;
      ALU_CODE_W'(alu_or):     alu_result = or_bits;
      ALU_CODE_W'(alu_xor):    alu_result = xor_bits;
      // Native signed compare, not a sign-of-difference trick, so it stays
      // correct when a-b overflows.
      ALU_CODE_W'(alu_slt):    alu_result = DATA_WIDTH'($signed(alu_in_a) < $signed(alu_in_b));
      ALU_CODE_W'(alu_sltu):   alu_result = DATA_WIDTH'(alu_in_a < alu_in_b);
      ALU_CODE_W'(alu_sll):    alu_result = alu_in_a << shamt;
      ALU_CODE_W'(alu_srl):    alu_result = alu_in_a >> shamt;
      ALU_CODE_W'(alu_sra):    alu_result = $signed(alu_in_a) >>> shamt;
      ALU_CODE_W'(alu_mul):    begin is_iter = 1'b1; mdu_op = mdu_mul;    end
      ALU_CODE_W'(alu_mulh):   begin is_iter = 1'b1; mdu_op = mdu_mulh;   end
      ALU_CODE_W'(alu_mulhsu): begin is_iter = 1'b1; mdu_op = mdu_mulhsu; end
      ALU_CODE_W'(alu_mulhu):  begin is_iter = 1'b1; mdu_op = mdu_mulhu;  end
      ALU_CODE_W'(alu_div):    begin is_iter = 1'b1; mdu_op = mdu_div;    end
      ALU_CODE_W'(alu_divu):   begin is_iter = 1'b1; mdu_op = mdu_divu;   end
      ALU_CODE_W'(alu_rem):    begin is_iter = 1'b1; mdu_op = mdu_rem;    end
      ALU_CODE_W'(alu_remu):   begin is_iter = 1'b1; mdu_op = mdu_remu;   end
      default:                 alu_result = '0;
    endcase
  end

  assign accept = alu_in_valid & alu_in_ready;

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= st_idle;
    else     state_reg <= state_next;
  end

  // FSM: next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      st_idle: if (accept) state_next = is_iter ? st_calc : st_done;
      st_calc: if (iter_last) state_next = st_done;
      st_done: begin
        if (accept)             state_next = is_iter ? st_calc : st_done;
        else if (alu_out_ready) state_next = st_idle;
      end
      default: state_next = st_idle;
    endcase
  end

  // FSM: outputs. rst gates ready directly so nothing is accepted while
  // reset is still asserted.
  always_comb begin
    alu_in_ready  = 1'b0;
    alu_busy      = 1'b0;
    alu_out_valid = 1'b0;
    case (state_reg)
      st_idle: alu_in_ready = ~rst;
      st_calc: alu_busy     = 1'b1;
      st_done: begin
        alu_out_valid = 1'b1;
        alu_in_ready  = alu_out_ready & ~rst;
      end
      default: ;
    endcase
  end

  // Result register: loaded only on acceptance of a single-cycle op or on
  // the final iterative step, so it holds while a result waits in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      alu_out_reg <= '0;
    else if (accept && !is_iter)  alu_out_reg <= alu_result;
    else if (iter_last)           alu_out_reg <= iter_result;
  end

  assign alu_out = alu_out_reg;

  core_mdu_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mdu_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (accept & is_iter),
    .op      (mdu_op),
    .op_a    (alu_in_a),
    .op_b    (alu_in_b),
    .step_en (state_reg == st_calc),
    .last    (iter_last),
    .result  (iter_result)
  );

endmodule
